fir_ap_ctrl: RTL and testbench

Control and sequencing block for the FIR core. It owns the ap_start/ap_done/ap_idle control register and the data_length register, and decodes the AXI-lite register map. It counts AXI-Stream input and output beats and generates sm_tlast and end-of-run. It also arbitrates the single tap BRAM port between AXI-lite coefficient access and the MAC engine's tap fetches.

---
 rtl/fir_ap_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fir_ap_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ap_ctrl.sv
// fir_ap_ctrl: run sequencing, AXI-lite register decode, stream beat counting
// and tap BRAM port arbitration for the FIR core.
//
// state  | meaning
// IDLE   | no run since reset; config owns the tap BRAM port
// RUN    | run in progress; engine owns the tap BRAM port
// DONE   | last output beat sent; config owns the tap BRAM port
module fir_ap_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_we,
  input  logic [pADDR_WIDTH-1:0] cfg_waddr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  input  logic                   cfg_re,
  input  logic [pADDR_WIDTH-1:0] cfg_raddr,
  output logic                   cfg_rvalid,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  input  logic                   ss_hs,
  input  logic                   sm_hs,
  output logic                   ss_en,
  output logic                   sm_tlast,
  output logic                   eng_start,
  input  logic                   eng_tap_req,
  input  logic [3:0]             eng_tap_idx,
  output logic                   eng_tap_gnt,
  output logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
  localparam logic [pADDR_WIDTH-1:0] TAP_END   = pADDR_WIDTH'(32 + 4 * Tape_Num);

  function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
    return (a >= TAP_BASE) && (a < TAP_END) && (a[1:0] == 2'b00);
  endfunction

  state_t                 state_q, state_d;
  logic                   ap_done_q, ap_done_d;
  logic [31:0]            data_length_q, data_length_d;
  logic [31:0]            in_cnt_q, in_cnt_d;
  logic [31:0]            out_cnt_q, out_cnt_d;
  logic                   eng_start_q, eng_start_d;
  logic                   rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   rd_tap_q, rd_tap_d;
  logic                   pend_q, pend_d;
  logic [pADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

  logic run, w_tap, r_tap, collide, start;

  assign run         = (state_q == S_RUN);
  assign w_tap       = cfg_we & is_tap(cfg_waddr);
  assign r_tap       = cfg_re & is_tap(cfg_raddr);
  // A tap write and tap read in the same idle cycle both need the single port;
  // the write goes first and the read is replayed from the pending slot.
  assign collide     = w_tap & r_tap & ~run;
  assign start       = cfg_we & (cfg_waddr == ADDR_CTRL) & cfg_wdata[0] & ~run;

  assign ss_en       = run & (in_cnt_q < data_length_q);
  assign sm_tlast    = run & (out_cnt_q == data_length_q - 32'd1);
  assign ap_idle     = ~run;
  assign ap_done     = ap_done_q;
  assign eng_start   = eng_start_q;
  assign data_length = data_length_q;
  assign eng_tap_gnt = run & eng_tap_req;
  assign cfg_rvalid  = rvalid_q;
  assign cfg_rdata   = rd_tap_q ? tap_Do : rdata_q;

  // Run sequencing, counters, control registers and read-return pipeline.
  always_comb begin
    state_d       = state_q;
    ap_done_d     = ap_done_q;
    data_length_d = data_length_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    eng_start_d   = 1'b0;
    if (run) begin
      if (ss_hs && ss_en) in_cnt_d = in_cnt_q + 32'd1;
      if (sm_hs) out_cnt_d = out_cnt_q + 32'd1;
      if (sm_hs && sm_tlast) begin
        state_d   = S_DONE;
        ap_done_d = 1'b1;
      end
    end else begin
      if (cfg_we && (cfg_waddr == ADDR_LEN)) data_length_d = 32'(cfg_wdata);
      if (cfg_re && (cfg_raddr == ADDR_CTRL) && ap_done_q) ap_done_d = 1'b0;
      if (start) begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        if (data_length_q == 32'd0) begin
          state_d   = S_DONE;
          ap_done_d = 1'b1;
        end else begin
          state_d     = S_RUN;
          ap_done_d   = 1'b0;
          eng_start_d = 1'b1;
        end
      end
    end

    // Assumes AXI-lite never issues a new access the cycle a pending read replays.
    pend_d      = collide;
    pend_addr_d = cfg_raddr;
    rvalid_d    = pend_q | (cfg_re & ~collide);
    rd_tap_d    = pend_q | (r_tap & ~run & ~collide);
    rdata_d     = '0;
    if (cfg_re) begin
      if (cfg_raddr == ADDR_CTRL)  rdata_d = pDATA_WIDTH'({ap_idle, ap_done_q, 1'b0});
      else if (cfg_raddr == ADDR_LEN) rdata_d = pDATA_WIDTH'(data_length_q);
      else if (r_tap && run)       rdata_d = '1;
    end
  end

  // Tap BRAM port mux: engine during a run, otherwise pending read, write, read.
  always_comb begin
    tap_EN = 1'b0;
    tap_WE = 4'h0;
    tap_A  = '0;
    tap_Di = '0;
    if (run) begin
      tap_EN = eng_tap_req;
      tap_A  = pADDR_WIDTH'({eng_tap_idx, 2'b00});
    end else if (pend_q) begin
      tap_EN = 1'b1;
      tap_A  = pend_addr_q - TAP_BASE;
    end else if (w_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = cfg_waddr - TAP_BASE;
      tap_Di = cfg_wdata;
    end else if (r_tap) begin
      tap_EN = 1'b1;
      tap_A  = cfg_raddr - TAP_BASE;
    end
  end

  // All state registers with synchronous reset.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q       <= S_IDLE;
      ap_done_q     <= 1'b0;
      data_length_q <= '0;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      eng_start_q   <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      rd_tap_q      <= 1'b0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
    end else begin
      state_q       <= state_d;
      ap_done_q     <= ap_done_d;
      data_length_q <= data_length_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      eng_start_q   <= eng_start_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rd_tap_q      <= rd_tap_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
    end
  end

endmodule

// File: tb/tb_fir_ap_ctrl.sv
// Directed bench for fir_ap_ctrl with a behavioural tap BRAM.
module tb_fir_ap_ctrl;
  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        cfg_we = 1'b0, cfg_re = 1'b0;
  logic [11:0] cfg_waddr = '0, cfg_raddr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        cfg_rvalid;
  logic [31:0] cfg_rdata;
  logic        ss_hs = 1'b0, sm_hs = 1'b0;
  logic        ss_en, sm_tlast, eng_start;
  logic        eng_tap_req = 1'b0;
  logic [3:0]  eng_tap_idx = '0;
  logic        eng_tap_gnt;
  logic [31:0] data_length;
  logic        ap_idle, ap_done;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_Do;
  logic [11:0] tap_A;

  fir_ap_ctrl dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_wdata(cfg_wdata),
    .cfg_re(cfg_re), .cfg_raddr(cfg_raddr),
    .cfg_rvalid(cfg_rvalid), .cfg_rdata(cfg_rdata),
    .ss_hs(ss_hs), .sm_hs(sm_hs), .ss_en(ss_en), .sm_tlast(sm_tlast),
    .eng_start(eng_start), .eng_tap_req(eng_tap_req), .eng_tap_idx(eng_tap_idx),
    .eng_tap_gnt(eng_tap_gnt), .data_length(data_length),
    .ap_idle(ap_idle), .ap_done(ap_done),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap BRAM model: one-cycle registered read, word-wide write.
  logic [31:0] mem [0:15];
  int bram_wr = 0;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    tap_Do = '0;
  end
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) begin
        mem[tap_A[5:2]] <= tap_Di;
        bram_wr <= bram_wr + 1;
      end
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic cfg_write(input logic [11:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_waddr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string name, input logic [11:0] a, input logic [31:0] exp);
    cfg_re = 1'b1; cfg_raddr = a;
    tick();
    cfg_re = 1'b0;
    chk({name, " rvalid"}, 32'(cfg_rvalid), 32'd1);
    chk(name, cfg_rdata, exp);
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
  } op_t;

  op_t ops[$];
  int  taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int  tl_cnt, tl_beat, w0;

  initial begin
    // Reset state.
    repeat (3) tick();
    axis_rst = 1'b0;
    tick();
    chk("rst ap_idle", 32'(ap_idle), 32'd1);
    chk("rst ap_done", 32'(ap_done), 32'd0);
    chk("rst data_length", data_length, 32'd0);
    chk("rst rvalid", 32'(cfg_rvalid), 32'd0);
    chk("rst rdata", cfg_rdata, 32'd0);
    chk("rst eng_start", 32'(eng_start), 32'd0);
    chk("rst ss_en", 32'(ss_en), 32'd0);
    chk("rst gnt", 32'(eng_tap_gnt), 32'd0);
    chk("rst tap port", {tap_EN, tap_WE, tap_A}, 32'd0);
    chk("rst tap_Di", tap_Di, 32'd0);

    // Configuration table: writes then read-back with expected values.
    ops.push_back('{1'b1, 12'h010, 32'd600});
    for (int k = 0; k < 11; k++) ops.push_back('{1'b1, 12'(32 + 4 * k), 32'(taps[k])});
    ops.push_back('{1'b1, 12'h004, 32'hDEAD});
    for (int k = 0; k < 11; k++) ops.push_back('{1'b0, 12'(32 + 4 * k), 32'(taps[k])});
    ops.push_back('{1'b0, 12'h000, 32'h4});
    ops.push_back('{1'b0, 12'h010, 32'd600});
    ops.push_back('{1'b0, 12'h004, 32'h0});
    ops.push_back('{1'b0, 12'h04C, 32'h0});
    ops.push_back('{1'b0, 12'h022, 32'h0});

    for (int i = 0; i < ops.size(); i++) begin
      if (ops[i].wr) begin
        cfg_we = 1'b1; cfg_waddr = ops[i].addr; cfg_wdata = ops[i].data;
        #1;
        if (ops[i].addr >= 12'h020 && ops[i].addr < 12'h04C) begin
          chk($sformatf("tbl wr%0d port", i), {tap_EN, tap_WE, tap_A}, {15'd0, 1'b1, 4'hF, ops[i].addr - 12'h020});
          chk($sformatf("tbl wr%0d Di", i), tap_Di, ops[i].data);
        end
        tick();
        cfg_we = 1'b0;
      end else begin
        cfg_read($sformatf("tbl rd 0x%0h", ops[i].addr), ops[i].addr, ops[i].data);
      end
    end

    // Start a run of 600.
    cfg_write(12'h000, 32'h1);
    chk("start eng_start", 32'(eng_start), 32'd1);
    chk("start ap_idle", 32'(ap_idle), 32'd0);
    chk("start ss_en", 32'(ss_en), 32'd1);
    tick();
    chk("eng_start one pulse", 32'(eng_start), 32'd0);
    cfg_read("run ctrl", 12'h000, 32'h0);
    cfg_write(12'h000, 32'h1);
    chk("start in run ignored", 32'(eng_start), 32'd0);

    // Engine tap fetch during RUN.
    eng_tap_req = 1'b1; eng_tap_idx = 4'd5;
    #1;
    chk("eng gnt", 32'(eng_tap_gnt), 32'd1);
    chk("eng port", {tap_EN, tap_WE, tap_A}, {15'd0, 1'b1, 4'h0, 12'h014});
    tick();
    eng_tap_req = 1'b0;
    chk("eng tap5 data", tap_Do, 32'd63);

    // Config writes/reads during RUN.
    w0 = bram_wr;
    cfg_write(12'h02C, 32'd99);
    cfg_read("run tap3 read", 12'h02C, 32'hFFFF_FFFF);
    chk("run tap write dropped", 32'(bram_wr - w0), 32'd0);
    cfg_write(12'h010, 32'd5);
    cfg_read("run len write dropped", 12'h010, 32'd600);

    // 600 input beats.
    ss_hs = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 599) chk("ss_en beat 599", 32'(ss_en), 32'd1);
      tick();
    end
    chk("ss_en after 600", 32'(ss_en), 32'd0);
    tick();
    chk("ss_en stays low", 32'(ss_en), 32'd0);
    ss_hs = 1'b0;

    // 600 output beats; read ctrl on the last beat sees pre-edge status.
    tl_cnt = 0; tl_beat = -1;
    sm_hs = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (i == 599) begin cfg_re = 1'b1; cfg_raddr = 12'h000; end
      #1;
      if (sm_tlast) begin tl_cnt++; tl_beat = i; end
      @(posedge axis_clk); #1;
    end
    sm_hs = 1'b0; cfg_re = 1'b0;
    chk("last-edge ctrl rvalid", 32'(cfg_rvalid), 32'd1);
    chk("last-edge ctrl pre-edge", cfg_rdata, 32'h0);
    chk("tlast count", 32'(tl_cnt), 32'd1);
    chk("tlast beat", 32'(tl_beat), 32'd599);
    chk("done ap_done", 32'(ap_done), 32'd1);
    chk("done tlast low", 32'(sm_tlast), 32'd0);
    cfg_read("done ctrl", 12'h000, 32'h6);
    cfg_read("done ctrl cleared", 12'h000, 32'h4);
    chk("ap_done cleared", 32'(ap_done), 32'd0);
    cfg_read("done tap3", 12'h02C, 32'd23);
    eng_tap_req = 1'b1;
    #1;
    chk("done no gnt", 32'(eng_tap_gnt), 32'd0);
    eng_tap_req = 1'b0;

    // Same-cycle tap write and tap read.
    cfg_we = 1'b1; cfg_waddr = 12'h024; cfg_wdata = 32'd7;
    cfg_re = 1'b1; cfg_raddr = 12'h024;
    #1;
    chk("collide wr port", {tap_EN, tap_WE, tap_A}, {15'd0, 1'b1, 4'hF, 12'h004});
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    #1;
    chk("collide T+1 rvalid", 32'(cfg_rvalid), 32'd0);
    chk("collide T+1 port", {tap_EN, tap_WE, tap_A}, {15'd0, 1'b1, 4'h0, 12'h004});
    tick();
    chk("collide T+2 rvalid", 32'(cfg_rvalid), 32'd1);
    chk("collide T+2 rdata", cfg_rdata, 32'd7);

    // Same-cycle length write and tap read are both serviced.
    cfg_we = 1'b1; cfg_waddr = 12'h010; cfg_wdata = 32'd3;
    cfg_re = 1'b1; cfg_raddr = 12'h028;
    tick();
    cfg_we = 1'b0; cfg_re = 1'b0;
    chk("dual rvalid", 32'(cfg_rvalid), 32'd1);
    chk("dual tap2", cfg_rdata, 32'hFFFF_FFF7);
    cfg_read("dual len", 12'h010, 32'd3);

    // Reset mid-run.
    cfg_write(12'h010, 32'd600);
    cfg_write(12'h000, 32'h1);
    ss_hs = 1'b1; sm_hs = 1'b1;
    repeat (300) tick();
    ss_hs = 1'b0; sm_hs = 1'b0;
    chk("mid-run busy", 32'(ap_idle), 32'd0);
    axis_rst = 1'b1;
    tick();
    axis_rst = 1'b0;
    chk("mrst ap_idle", 32'(ap_idle), 32'd1);
    chk("mrst ap_done", 32'(ap_done), 32'd0);
    chk("mrst data_length", data_length, 32'd0);
    chk("mrst ss_en", 32'(ss_en), 32'd0);
    chk("mrst tlast", 32'(sm_tlast), 32'd0);
    cfg_write(12'h000, 32'h1);
    chk("zero-len no eng_start", 32'(eng_start), 32'd0);
    chk("zero-len ap_done", 32'(ap_done), 32'd1);
    chk("zero-len ap_idle", 32'(ap_idle), 32'd1);
    tick();
    chk("zero-len still no eng_start", 32'(eng_start), 32'd0);
    cfg_read("zero-len ctrl", 12'h000, 32'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
